spi_bus_regs: RTL and testbench
===============================

# spi_bus_regs

Register target behind the SPI-to-bus slave: decodes the 32-bit single-cycle-strobe bus it drives into ID, scratch, control and status registers. Also runs two synchronous FIFOs forming a mailbox: host→fabric (TX) and fabric→host (RX), with valid/ready streams on the fabric side. Read data is captured on the read strobe and held stable for the slave's dummy phase.

## Interface
Parameters:
- DEPTH, 16, entries per FIFO; power of 2, 2..128
- ID_VALUE, 32'h4742_0001, constant returned at ID register

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- bus_addr  in  32  byte address; valid whenever a strobe is high
- bus_wdata  in  32  write data; valid with bus_wen
- bus_ren  in  1  one-cycle read strobe
- bus_wen  in  1  one-cycle write strobe
- bus_rdata  out  32  registered read data, held until next bus_ren
- tx_data  out  32  TX FIFO head (first-word fall-through)
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  fabric consumes head when tx_valid & tx_ready
- rx_data  in  32  fabric word to host
- rx_valid  in  1  fabric offers rx_data
- rx_ready  out  1  RX FIFO not full
- irq  out  1  registered level interrupt

## Operation
- Decode: mapped only if bus_addr[31:5]==0 and bus_addr[1:0]==0; index = bus_addr[4:2].
- 0x00 ID: RO, ID_VALUE.
- 0x04 SCRATCH: RW 32 bit, reset 0.
- 0x08 CTRL: [0] irq_en_rx (RX non-empty), [1] irq_en_tx (TX empty), [2] irq_en_err; [3] tx_flush, [4] rx_flush: write-1 pulses, read as 0; reset 0.
- 0x0C STATUS: [7:0] tx_count, [15:8] rx_count, [16] tx_full, [17] rx_empty, [24] tx_ovf, [25] rx_unf. Bits 24/25 sticky, write-1-to-clear; other bits RO.
- 0x10 FIFO: write pushes bus_wdata into TX; read pops RX head.
- TX push when full: word dropped, tx_ovf set.
- RX read when empty: returns 0, no pop, rx_unf set.
- Unmapped read returns 32'h0; unmapped write ignored.
- Flush: count→0, pointers reset; a push/pop in the same cycle as a flush is discarded. A rx_valid&rx_ready transfer in the flush cycle is discarded.
- irq = (en_rx & !rx_empty) | (en_tx & tx_empty) | (en_err & (tx_ovf|rx_unf)).
- bus_ren and bus_wen in the same cycle are each processed independently. A write to STATUS W1C and a new error in the same cycle leave the flag set.

## Timing
- Reset values: bus_rdata=0, tx_valid=0, rx_ready=1, irq=0, tx_data=0; FIFOs empty, sticky flags clear.
- Read latency: bus_rdata valid the cycle after bus_ren; unchanged until next bus_ren.
- STATUS read value reflects state before that cycle's updates.
- Register writes take effect the cycle after bus_wen.
- FIFO push→visible at head/tx_valid: 1 cycle. Pop→next head: 1 cycle.
- Simultaneous push and pop on a FIFO: allowed in any state. Count unchanged when not full/empty. When full, the pop frees a slot and the push is accepted; no ovf is flagged. When empty, only the push succeeds.
- Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1, zero-extended into the 8-bit STATUS fields.
- irq registered: asserts 1 cycle after its condition becomes true.

## Structure
- Package spi_bus_regs_pkg: register offset localparams, STATUS/CTRL bit-index constants, reg_idx_t enum.
- Sub-module sync_fifo (WIDTH, DEPTH; push/pop/flush, FWFT head, count, full, empty), instanced twice.
- Top: decode, registers, sticky flags, read mux, irq.

## Test plan
- Reset, then read 0x00 → bus_rdata=32'h4742_0001 one cycle after bus_ren; read 0x0C → 32'h0002_0000.
- Write 0x04 ← 32'hA5A5_5A5A, read back → 32'hA5A5_5A5A; read 0x40 → 0.
- Write 0x10 with 17 words, tx_ready=0 → tx_count=16, tx_full=1, tx_ovf=1. Drain → words 0..15 in order. Write STATUS 32'h0100_0000 → tx_ovf=0.
- Fabric pushes 3 words (1,2,3); reads of 0x10 → 1,2,3. Fourth read → 0 with rx_unf=1; rx_ready=0 only after 16 pushes.
- CTRL=32'h1, then one RX push → irq=1 one cycle later; pop → irq=0. CTRL write 32'h10 with 5 queued → rx_count=0.
- Full TX FIFO, bus_wen to 0x10 with tx_ready=1 same cycle → count stays 16, no ovf. rst_n low mid-sequence → all outputs at reset values next cycle.

Source files
------------

// File: rtl/spi_bus_regs_pkg.sv
// Shared constants for the SPI bus register target: register offsets,
// CTRL/STATUS bit positions, word-index enum and the address decode helper.
// Pure declarations; no timing or flow-control behaviour lives here.
package spi_bus_regs_pkg;

  localparam logic [31:0] OFF_ID      = 32'h00;
  localparam logic [31:0] OFF_SCRATCH = 32'h04;
  localparam logic [31:0] OFF_CTRL    = 32'h08;
  localparam logic [31:0] OFF_STATUS  = 32'h0C;
  localparam logic [31:0] OFF_FIFO    = 32'h10;

  localparam int CTRL_IRQ_EN_RX  = 0;
  localparam int CTRL_IRQ_EN_TX  = 1;
  localparam int CTRL_IRQ_EN_ERR = 2;
  localparam int CTRL_TX_FLUSH   = 3;
  localparam int CTRL_RX_FLUSH   = 4;

  localparam int STAT_TX_COUNT_LSB = 0;
  localparam int STAT_RX_COUNT_LSB = 8;
  localparam int STAT_TX_FULL      = 16;
  localparam int STAT_RX_EMPTY     = 17;
  localparam int STAT_TX_OVF       = 24;
  localparam int STAT_RX_UNF       = 25;

  typedef enum logic [2:0] {
    IDX_ID      = 3'd0,
    IDX_SCRATCH = 3'd1,
    IDX_CTRL    = 3'd2,
    IDX_STATUS  = 3'd3,
    IDX_FIFO    = 3'd4,
    IDX_RSVD5   = 3'd5,
    IDX_RSVD6   = 3'd6,
    IDX_RSVD7   = 3'd7
  } reg_idx_t;

  // Only word-aligned addresses inside the first 32 bytes hit a register.
  function automatic logic addr_mapped(input logic [31:0] addr);
    return (addr[31:5] == 27'd0) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/spi_bus_regs_if.sv
// Bundles the strobe bus from the SPI slave plus the fabric TX/RX streams.
// No logic; latency and flow control are defined by the attached modules.
// master = SPI slave + fabric side, slave = register target.
interface spi_bus_regs_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_rdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  modport master (
    output bus_addr, bus_wdata, bus_ren, bus_wen, tx_ready, rx_data, rx_valid,
    input  bus_rdata, tx_data, tx_valid, rx_ready, irq
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_ren, bus_wen, tx_ready, rx_data, rx_valid,
    output bus_rdata, tx_data, tx_valid, rx_ready, irq
  );
endinterface

// File: rtl/spi_bus_regs_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and synchronous flush.
// Push visible at head one cycle later; pop advances head one cycle later.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_q;
  // Head is forced to zero when empty so it never exposes stale storage.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; flush overrides any transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer/count state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spi_bus_regs.sv
// Register target: ID/SCRATCH/CTRL/STATUS registers plus a TX/RX mailbox.
// Read data registered one cycle after bus_ren and held; irq registered.
// Fabric streams use valid/ready; overflow/underflow on the bus side set sticky flags.
module spi_bus_regs
  import spi_bus_regs_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] ID_VALUE = 32'h4742_0001
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_bus_regs_if.slave  bif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] scratch_q, scratch_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_unf_q, rx_unf_d;
  logic        irq_q, irq_d;

  logic          mapped;
  reg_idx_t      idx;
  logic          rd_hit, wr_hit;
  logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [31:0]   rx_head, status;
  logic          tx_ovf_set, rx_unf_set;

  assign mapped = addr_mapped(bif.bus_addr);
  assign idx    = reg_idx_t'(bif.bus_addr[4:2]);
  assign rd_hit = bif.bus_ren & mapped;
  assign wr_hit = bif.bus_wen & mapped;

  assign tx_flush = wr_hit && (idx == IDX_CTRL) && bif.bus_wdata[CTRL_TX_FLUSH];
  assign rx_flush = wr_hit && (idx == IDX_CTRL) && bif.bus_wdata[CTRL_RX_FLUSH];
  assign tx_push  = wr_hit && (idx == IDX_FIFO);
  assign tx_pop   = bif.tx_valid & bif.tx_ready;
  assign rx_push  = bif.rx_valid & ~rx_full;
  assign rx_pop   = rd_hit && (idx == IDX_FIFO) && !rx_empty;

  // A full-FIFO push is only an overflow if the fabric is not popping that cycle.
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop & ~tx_flush;
  assign rx_unf_set = rd_hit && (idx == IDX_FIFO) && rx_empty;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tx_push), .push_data(bif.bus_wdata), .pop(tx_pop), .flush(tx_flush),
    .head(bif.tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_push), .push_data(bif.rx_data), .pop(rx_pop), .flush(rx_flush),
    .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  assign bif.tx_valid  = ~tx_empty;
  assign bif.rx_ready  = ~rx_full;
  assign bif.bus_rdata = rdata_q;
  assign bif.irq       = irq_q;

  // STATUS snapshot from current (pre-update) state.
  always_comb begin
    status = '0;
    status[STAT_TX_COUNT_LSB +: 8] = 8'(tx_count);
    status[STAT_RX_COUNT_LSB +: 8] = 8'(rx_count);
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_RX_EMPTY] = rx_empty;
    status[STAT_TX_OVF]   = tx_ovf_q;
    status[STAT_RX_UNF]   = rx_unf_q;
  end

  // Register writes, sticky flags, read mux and interrupt next-state.
  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    rdata_d   = rdata_q;
    tx_ovf_d  = tx_ovf_q;
    rx_unf_d  = rx_unf_q;

    if (wr_hit && idx == IDX_SCRATCH) scratch_d = bif.bus_wdata;
    if (wr_hit && idx == IDX_CTRL)    ctrl_d    = bif.bus_wdata[2:0];
    if (wr_hit && idx == IDX_STATUS) begin
      if (bif.bus_wdata[STAT_TX_OVF]) tx_ovf_d = 1'b0;
      if (bif.bus_wdata[STAT_RX_UNF]) rx_unf_d = 1'b0;
    end
    // New errors win over a same-cycle clear.
    if (tx_ovf_set) tx_ovf_d = 1'b1;
    if (rx_unf_set) rx_unf_d = 1'b1;

    if (bif.bus_ren) begin
      rdata_d = 32'h0;
      if (mapped) begin
        case (idx)
          IDX_ID:      rdata_d = ID_VALUE;
          IDX_SCRATCH: rdata_d = scratch_q;
          IDX_CTRL:    rdata_d = {29'd0, ctrl_q};
          IDX_STATUS:  rdata_d = status;
          IDX_FIFO:    rdata_d = rx_head;
          default:     rdata_d = 32'h0;
        endcase
      end
    end

    irq_d = (ctrl_q[CTRL_IRQ_EN_RX]  & ~rx_empty) |
            (ctrl_q[CTRL_IRQ_EN_TX]  &  tx_empty) |
            (ctrl_q[CTRL_IRQ_EN_ERR] & (tx_ovf_q | rx_unf_q));
  end

  // Register state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      scratch_q <= '0;
      ctrl_q    <= '0;
      tx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_unf_q  <= rx_unf_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_spi_bus_regs.sv
// Directed bench for spi_bus_regs: register vector table plus
// hand-written FIFO, interrupt, flush and reset sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_spi_bus_regs;
  import spi_bus_regs_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  spi_bus_regs_if bif();

  spi_bus_regs #(.DEPTH(16), .ID_VALUE(32'h4742_0001)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bif(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bif.bus_addr  = addr;
    bif.bus_wdata = data;
    bif.bus_wen   = 1'b1;
    step();
    bif.bus_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bif.bus_addr = addr;
    bif.bus_ren  = 1'b1;
    step();
    bif.bus_ren  = 1'b0;
    data = bif.bus_rdata;
  endtask

  task automatic rx_send(input logic [31:0] data);
    bif.rx_data  = data;
    bif.rx_valid = 1'b1;
    step();
    bif.rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{1'b0, OFF_ID,      32'h0,         32'h4742_0001};
    vecs[1]  = '{1'b0, OFF_STATUS,  32'h0,         32'h0002_0000};
    vecs[2]  = '{1'b1, OFF_SCRATCH, 32'hA5A5_5A5A, 32'h0};
    vecs[3]  = '{1'b0, OFF_SCRATCH, 32'h0,         32'hA5A5_5A5A};
    vecs[4]  = '{1'b0, 32'h40,      32'h0,         32'h0};
    vecs[5]  = '{1'b0, 32'h06,      32'h0,         32'h0};
    vecs[6]  = '{1'b1, 32'h44,      32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{1'b0, OFF_SCRATCH, 32'h0,         32'hA5A5_5A5A};
    vecs[8]  = '{1'b1, OFF_CTRL,    32'h0000_001F, 32'h0};
    vecs[9]  = '{1'b0, OFF_CTRL,    32'h0,         32'h0000_0007};
    vecs[10] = '{1'b1, OFF_CTRL,    32'h0,         32'h0};
    vecs[11] = '{1'b0, OFF_CTRL,    32'h0,         32'h0};
    vecs[12] = '{1'b0, 32'h14,      32'h0,         32'h0};
    vecs[13] = '{1'b0, 32'h104,     32'h0,         32'h0};

    rst_n         = 1'b0;
    bif.bus_addr  = '0;
    bif.bus_wdata = '0;
    bif.bus_ren   = 1'b0;
    bif.bus_wen   = 1'b0;
    bif.tx_ready  = 1'b0;
    bif.rx_data   = '0;
    bif.rx_valid  = 1'b0;
    step();
    step();
    chk("rst_rdata",    bif.bus_rdata, 32'h0);
    chk("rst_tx_valid", {31'd0, bif.tx_valid}, 32'h0);
    chk("rst_tx_data",  bif.tx_data, 32'h0);
    chk("rst_rx_ready", {31'd0, bif.rx_ready}, 32'h1);
    chk("rst_irq",      {31'd0, bif.irq}, 32'h0);
    rst_n = 1'b1;
    step();

    // Register-level vector table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end
    // Held read data: idle cycles leave bus_rdata unchanged
    bus_read(OFF_ID, rd);
    step();
    step();
    chk("rdata_hold", bif.bus_rdata, 32'h4742_0001);

    // TX: 17 pushes with fabric stalled
    for (int i = 0; i < 17; i++) bus_write(OFF_FIFO, i);
    bus_read(OFF_STATUS, rd);
    chk("tx_full_status", rd, 32'h0103_0010);
    chk("tx_head0", bif.tx_data, 32'h0);
    chk("tx_valid_full", {31'd0, bif.tx_valid}, 32'h1);
    bus_write(OFF_CTRL, 32'h4);
    step();
    chk("irq_err", {31'd0, bif.irq}, 32'h1);
    bif.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tx_drain%0d", i), bif.tx_data, i);
      step();
    end
    bif.tx_ready = 1'b0;
    chk("tx_valid_empty", {31'd0, bif.tx_valid}, 32'h0);
    bus_write(OFF_STATUS, 32'h0100_0000);
    bus_read(OFF_STATUS, rd);
    chk("tx_ovf_clear", rd, 32'h0002_0000);
    chk("irq_err_clear", {31'd0, bif.irq}, 32'h0);
    bus_write(OFF_CTRL, 32'h0);

    // RX: three words, then underflow
    rx_send(32'd1);
    rx_send(32'd2);
    rx_send(32'd3);
    for (int i = 1; i <= 3; i++) begin
      bus_read(OFF_FIFO, rd);
      chk($sformatf("rx_pop%0d", i), rd, i);
    end
    bus_read(OFF_FIFO, rd);
    chk("rx_unf_data", rd, 32'h0);
    bus_read(OFF_STATUS, rd);
    chk("rx_unf_status", rd, 32'h0202_0000);
    bus_write(OFF_STATUS, 32'h0200_0000);
    for (int i = 0; i < 16; i++) begin
      if (bif.rx_ready !== 1'b1) chk($sformatf("rx_ready%0d", i), {31'd0, bif.rx_ready}, 32'h1);
      rx_send(32'h100 + i);
    end
    chk("rx_ready_full", {31'd0, bif.rx_ready}, 32'h0);
    bus_read(OFF_STATUS, rd);
    chk("rx_full_status", rd, 32'h0000_1000);
    bus_write(OFF_CTRL, 32'h10);
    bus_read(OFF_STATUS, rd);
    chk("rx_flush16", rd, 32'h0002_0000);

    // Flush with 5 queued
    for (int i = 0; i < 5; i++) rx_send(32'h200 + i);
    bus_read(OFF_STATUS, rd);
    chk("rx5_status", rd, 32'h0000_0500);
    bus_write(OFF_CTRL, 32'h10);
    bus_read(OFF_STATUS, rd);
    chk("rx_flush5", rd, 32'h0002_0000);
    chk("rx_ready_flush", {31'd0, bif.rx_ready}, 32'h1);

    // IRQ on RX non-empty: registered one cycle after the condition
    bus_write(OFF_CTRL, 32'h1);
    chk("irq_idle", {31'd0, bif.irq}, 32'h0);
    rx_send(32'h55);
    chk("irq_not_early", {31'd0, bif.irq}, 32'h0);
    step();
    chk("irq_rx_set", {31'd0, bif.irq}, 32'h1);
    bus_read(OFF_FIFO, rd);
    chk("irq_pop_data", rd, 32'h55);
    step();
    chk("irq_rx_clear", {31'd0, bif.irq}, 32'h0);
    bus_write(OFF_CTRL, 32'h0);

    // Full TX with simultaneous push and fabric pop
    for (int i = 0; i < 16; i++) bus_write(OFF_FIFO, 32'd100 + i);
    bif.bus_addr  = OFF_FIFO;
    bif.bus_wdata = 32'hDEAD;
    bif.bus_wen   = 1'b1;
    bif.tx_ready  = 1'b1;
    step();
    bif.bus_wen   = 1'b0;
    bif.tx_ready  = 1'b0;
    bus_read(OFF_STATUS, rd);
    chk("tx_full_pushpop", rd, 32'h0003_0010);
    chk("tx_head_after", bif.tx_data, 32'd101);

    // Reset mid-sequence with irq high and FIFOs occupied
    rx_send(32'h77);
    bus_write(OFF_CTRL, 32'h1);
    step();
    chk("irq_pre_rst", {31'd0, bif.irq}, 32'h1);
    bus_read(OFF_STATUS, rd);
    chk("status_pre_rst", rd, 32'h0001_0110);
    rst_n = 1'b0;
    step();
    chk("mrst_rdata",    bif.bus_rdata, 32'h0);
    chk("mrst_tx_valid", {31'd0, bif.tx_valid}, 32'h0);
    chk("mrst_tx_data",  bif.tx_data, 32'h0);
    chk("mrst_rx_ready", {31'd0, bif.rx_ready}, 32'h1);
    chk("mrst_irq",      {31'd0, bif.irq}, 32'h0);
    rst_n = 1'b1;
    step();
    bus_read(OFF_STATUS, rd);
    chk("post_rst_status", rd, 32'h0002_0000);
    bus_read(OFF_SCRATCH, rd);
    chk("post_rst_scratch", rd, 32'h0);
    bus_read(OFF_CTRL, rd);
    chk("post_rst_ctrl", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
